cache_ctrl: RTL and testbench

Sequencing controller for the 4-line, 8-bit fully associative cache and its multi-cycle backing RAM.
- Accepts one read/write request at a time from the core.
- Performs the tag lookup and maintains per-line valid bits and true-LRU ages.
- Fetches from RAM on read miss, allocates on write miss; write-through on every write.
- Sits between the core request port and the RAM, and owns the line registers (tag/data).

---
 rtl/cache_ctrl_pkg.sv | 18 +
 rtl/cache_lru4.sv | 36 +++
 rtl/cache_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared constants for the 4-line fully associative cache controller:
// FSM state encoding, line/age geometry and request polarity.
package cache_ctrl_pkg;

  localparam int N_LINES = 4;
  localparam int AGE_W   = 2;
  localparam int IDX_W   = 2;
  localparam logic WRITE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOOKUP = 4'd1,
    ST_MEM_RD = 4'd2,
    ST_MEM_WR = 4'd3,
    ST_DONE   = 4'd4
  } state_e;

endpackage

// File: rtl/cache_lru4.sv
// True-LRU age tracker for four lines: ages stay a permutation of 0..3,
// and the victim is the lowest invalid line, otherwise the oldest.
module cache_lru4
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               touch,
  input  logic [IDX_W-1:0]   touch_idx,
  input  logic [N_LINES-1:0] valid,
  output logic [IDX_W-1:0]   victim
);

  logic [AGE_W-1:0] age_q [N_LINES];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < N_LINES; i++) age_q[i] <= AGE_W'(i);
    end else if (touch) begin
      for (int i = 0; i < N_LINES; i++) begin
        if (IDX_W'(i) == touch_idx) age_q[i] <= '0;
        else if (age_q[i] < age_q[touch_idx]) age_q[i] <= age_q[i] + 1'b1;
      end
    end
  end

  // Invalid lines win over the age-3 line; the descending scan leaves the lowest index.
  always_comb begin
    victim = '0;
    for (int i = 0; i < N_LINES; i++)
      if (age_q[i] == AGE_W'(N_LINES - 1)) victim = IDX_W'(i);
    for (int i = N_LINES - 1; i >= 0; i--)
      if (!valid[i]) victim = IDX_W'(i);
  end

endmodule

// File: rtl/cache_ctrl.sv
// Request sequencer for a 4-line fully associative write-through cache in
// front of a variable-latency RAM; owns the tag/data line registers.
module cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int LINES = N_LINES
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          enab,
  input  logic          req,
  input  logic          rw,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          flush,
  output logic          busy,
  output logic          ack,
  output logic [DW-1:0] rdata,
  output logic          hit,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [3:0]    state,
  output logic [7:0]    hit_cnt,
  output logic [7:0]    miss_cnt
);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_e state_q, state_d;

  logic             rw_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [LINES-1:0] valid_q;
  logic [AW-1:0]    tag_q  [LINES];
  logic [DW-1:0]    data_q [LINES];
  logic             lookup_hit_q;
  logic [DW-1:0]    rdata_q;
  logic             hit_q;
  logic [7:0]       hit_cnt_q, miss_cnt_q;

  logic             hit_any;
  logic [IDX_W-1:0] hit_idx;
  logic [IDX_W-1:0] victim;
  logic             touch;
  logic [IDX_W-1:0] touch_idx;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && tag_q[i] == addr_q) begin
        hit_any = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Hits and write allocations age in LOOKUP; read misses age when the fill lands.
  assign touch     = (state_q == ST_LOOKUP && (hit_any || rw_q == WRITE)) ||
                     (state_q == ST_MEM_RD && mem_ack);
  assign touch_idx = hit_any ? hit_idx : victim;

  cache_lru4 u_lru (
    .clk       (clk),
    .clr       (clr),
    .touch     (touch),
    .touch_idx (touch_idx),
    .valid     (valid_q),
    .victim    (victim)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (!flush && req && enab) state_d = ST_LOOKUP;
      ST_LOOKUP: begin
        if (rw_q == WRITE) state_d = ST_MEM_WR;
        else if (hit_any)  state_d = ST_DONE;
        else               state_d = ST_MEM_RD;
      end
      ST_MEM_RD: if (mem_ack) state_d = ST_DONE;
      ST_MEM_WR: if (mem_ack) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      valid_q      <= '0;
      lookup_hit_q <= 1'b0;
      rdata_q      <= '0;
      hit_q        <= 1'b0;
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flush) begin
            valid_q <= '0;
          end else if (req && enab) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
          end
        end
        ST_LOOKUP: begin
          lookup_hit_q <= hit_any;
          if (hit_any) hit_cnt_q  <= sat_inc(hit_cnt_q);
          else         miss_cnt_q <= sat_inc(miss_cnt_q);
          if (rw_q == WRITE) begin
            if (hit_any) begin
              data_q[hit_idx] <= wdata_q;
            end else begin
              tag_q[victim]   <= addr_q;
              data_q[victim]  <= wdata_q;
              valid_q[victim] <= 1'b1;
            end
          end else if (hit_any) begin
            rdata_q <= data_q[hit_idx];
            hit_q   <= 1'b1;
          end
        end
        ST_MEM_RD: begin
          if (mem_ack) begin
            tag_q[victim]   <= addr_q;
            data_q[victim]  <= mem_rdata;
            valid_q[victim] <= 1'b1;
            rdata_q         <= mem_rdata;
            hit_q           <= 1'b0;
          end
        end
        ST_MEM_WR: if (mem_ack) hit_q <= lookup_hit_q;
        default: ;
      endcase
    end
  end

  // RAM-side outputs decode straight from the state so an async reset drops them at once.
  assign busy      = (state_q != ST_IDLE);
  assign ack       = (state_q == ST_DONE);
  assign mem_req   = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);
  assign mem_we    = (state_q == ST_MEM_WR);
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign rdata     = rdata_q;
  assign hit       = hit_q;
  assign state     = state_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: vector table of accesses with hand-derived
// results, plus sequences for async reset, flush, saturation and enab.
module tb_cache_ctrl;

  logic       clk = 1'b0;
  logic       clr, enab, req, rw, flush, mem_ack;
  logic [7:0] addr, wdata, mem_rdata;
  logic       busy, ack, hit, mem_req, mem_we;
  logic [7:0] rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  cache_ctrl dut (
    .clk(clk), .clr(clr), .enab(enab), .req(req), .rw(rw), .addr(addr),
    .wdata(wdata), .flush(flush), .busy(busy), .ack(ack), .rdata(rdata),
    .hit(hit), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .state(state), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic [7:0] a;
    logic [7:0] d;
    int         lat;
    logic [7:0] mrd;
    logic [7:0] erd;
    logic       ehit;
    logic       emem;
  } vec_t;

  vec_t tbl [16];

  logic [7:0] r_rd;
  logic       r_hit, r_membad, r_ackwide, r_busy_after;
  int         r_lat, r_memcyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Issues one request and plays the RAM, acking after lat cycles of mem_req.
  task automatic do_access(input logic w, input logic [7:0] a, input logic [7:0] d,
                           input int lat, input logic [7:0] mrd);
    int cyc;
    cyc = 0;
    r_memcyc = 0;
    r_membad = 1'b0;
    @(negedge clk);
    req = 1'b1; rw = w; addr = a; wdata = d; enab = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (ack) break;
      if (mem_req) begin
        r_memcyc++;
        if (mem_addr !== a || mem_we !== w || mem_wdata !== (w ? d : 8'h00)) r_membad = 1'b1;
        if (r_memcyc >= lat) begin
          mem_ack = 1'b1;
          mem_rdata = mrd;
        end
      end else if (mem_addr !== 8'h00 || mem_we !== 1'b0 || mem_wdata !== 8'h00) begin
        r_membad = 1'b1;
      end
    end
    r_lat = cyc;
    r_rd  = rdata;
    r_hit = hit;
    @(negedge clk);
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    r_ackwide = ack;
    r_busy_after = busy;
  endtask

  initial begin
    int exp_hits, exp_miss, acks, n, bad;
    clr = 1'b0; enab = 1'b0; req = 1'b0; rw = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; addr = 8'h00; wdata = 8'h00; mem_rdata = 8'h00;

    //            w     a      d      lat mrd    erd    hit   mem
    tbl[0]  = '{1'b0, 8'h0F, 8'h00, 3, 8'hAF, 8'hAF, 1'b0, 1'b1};
    tbl[1]  = '{1'b0, 8'h0F, 8'h00, 0, 8'h00, 8'hAF, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h0F, 8'hC0, 2, 8'h00, 8'hAF, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h0F, 8'h00, 0, 8'h00, 8'hC0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h01, 8'h00, 1, 8'h11, 8'h11, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 8'h02, 8'h00, 2, 8'h22, 8'h22, 1'b0, 1'b1};
    tbl[6]  = '{1'b0, 8'h03, 8'h00, 1, 8'h33, 8'h33, 1'b0, 1'b1};
    tbl[7]  = '{1'b0, 8'h04, 8'h00, 4, 8'h44, 8'h44, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h01, 8'h00, 0, 8'h00, 8'h11, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h05, 8'h00, 1, 8'h55, 8'h55, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 8'h02, 8'h00, 1, 8'h2B, 8'h2B, 1'b0, 1'b1};
    tbl[11] = '{1'b0, 8'h01, 8'h00, 0, 8'h00, 8'h11, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 8'h0F, 8'h00, 2, 8'hF0, 8'hF0, 1'b0, 1'b1};
    tbl[13] = '{1'b1, 8'h60, 8'h5A, 1, 8'h00, 8'hF0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 8'h60, 8'h00, 0, 8'h00, 8'h5A, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 8'h05, 8'h00, 1, 8'h5F, 8'h5F, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_ctl", {busy, ack, mem_req, mem_we, hit}, 5'b0);
    check("rst_data", {rdata, mem_addr, mem_wdata}, 24'h0);
    check("rst_cnt", {hit_cnt, miss_cnt}, 16'h0);
    clr = 1'b1;

    exp_hits = 0;
    exp_miss = 0;
    foreach (tbl[i]) begin
      do_access(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].lat, tbl[i].mrd);
      if (tbl[i].ehit) exp_hits++; else exp_miss++;
      check($sformatf("v%0d_rdata", i), r_rd, tbl[i].erd);
      check($sformatf("v%0d_hit", i), r_hit, tbl[i].ehit);
      check($sformatf("v%0d_memcyc", i), r_memcyc, tbl[i].emem ? tbl[i].lat : 0);
      check($sformatf("v%0d_latency", i), r_lat, tbl[i].emem ? 2 + tbl[i].lat : 2);
      check($sformatf("v%0d_memif", i), r_membad, 1'b0);
      check($sformatf("v%0d_ack1cyc", i), {r_ackwide, r_busy_after}, 2'b00);
      check($sformatf("v%0d_rdhold", i), rdata, tbl[i].erd);
    end
    check("tbl_hit_cnt", hit_cnt, exp_hits);
    check("tbl_miss_cnt", miss_cnt, exp_miss);

    // Async reset while the RAM read is outstanding.
    @(negedge clk);
    req = 1'b1; rw = 1'b0; addr = 8'h33; enab = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("mid_rst_reached_mem", mem_req, 1'b1);
    #2 clr = 1'b0;
    #1;
    check("mid_rst_mem_req", mem_req, 1'b0);
    check("mid_rst_state", {busy, state}, 5'd0);
    check("mid_rst_cnt", {hit_cnt, miss_cnt}, 16'h0);
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (ack) acks++;
    end
    clr = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ack) acks++;
    end
    check("mid_rst_no_ack", acks, 0);
    do_access(1'b0, 8'h33, 8'h00, 2, 8'h3C);
    check("post_rst_miss", r_hit, 1'b0);
    check("post_rst_rdata", r_rd, 8'h3C);
    check("post_rst_memcyc", r_memcyc, 2);

    // flush and req in the same IDLE cycle: flush wins, req is lost.
    @(negedge clk);
    flush = 1'b1; req = 1'b1; rw = 1'b0; addr = 8'h33; enab = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0; req = 1'b0;
    @(negedge clk);
    check("flush_req_dropped", {busy, state}, 5'd0);
    do_access(1'b0, 8'h33, 8'h00, 1, 8'h3D);
    check("post_flush_miss", r_hit, 1'b0);
    check("post_flush_rdata", r_rd, 8'h3D);

    // 256 read hits push hit_cnt into saturation.
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      do_access(1'b0, 8'h33, 8'h00, 0, 8'h00);
      if (r_hit !== 1'b1 || r_rd !== 8'h3D || r_memcyc != 0) bad++;
    end
    check("sat_loop_hits", bad, 0);
    check("sat_hit_cnt", hit_cnt, 8'd255);
    check("sat_miss_cnt", miss_cnt, 8'd2);
    do_access(1'b0, 8'h77, 8'h00, 1, 8'h70);
    check("sat_hold_hit_cnt", hit_cnt, 8'd255);
    check("sat_next_miss_cnt", miss_cnt, 8'd3);

    // A request while enab is low is never accepted.
    @(negedge clk);
    enab = 1'b0; req = 1'b1; addr = 8'h33;
    acks = 0;
    repeat (4) begin
      @(negedge clk);
      if (busy || ack) acks++;
    end
    req = 1'b0; enab = 1'b1;
    check("enab_low_ignored", acks, 0);
    check("enab_low_cnt", {hit_cnt, miss_cnt}, {8'd255, 8'd3});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
